escalonador_aprovados: RTL and testbench

Sequencing controller for the active-node evaluator in the shortest-path datapath. Each round it:
- scans every occupied active slot through a one-cycle-latency read port and takes the minimum criterion as the threshold;
- drives that threshold back to the evaluator and snapshots the evaluator's approved vector;
- hands each approved slot to the expansion stage over a valid/ready handshake;
- pulses a removal request for each slot after it is accepted.

---
 rtl/escalonador_aprovados.sv | 211 +++++++++++++++++++++
 tb/tb_escalonador_aprovados.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_aprovados.sv
// escalonador_aprovados: round sequencer for the active-node evaluator.
// Each round scans all slots for the minimum criterion among occupied ones,
// publishes it as the evaluator threshold, snapshots the approved set and
// dispatches every approved slot over valid/ready, following each accepted
// slot with a one-cycle removal pulse.
//
// Ports:
//   clk_in, rst_n_in             clock (rising edge), async active-low reset
//   iniciar_in / ocupado_out     round start request / round in progress
//   valido_in                    slot-occupied flags, captured at round start
//   ler_out, ler_slot_out        criterion store read strobe and slot
//   criterio_in                  criterion of the slot read one cycle earlier
//   treshold_out                 registered threshold (minimum criterion)
//   aprovados_in                 evaluator approved flags, sampled in CAPTURAR
//   despacho_valido_out/_slot_out, despacho_pronto_in   dispatch handshake
//   remover_out, remover_slot_out                       removal pulse
//   fim_rodada_out               one-cycle end-of-round pulse
//   vazio_out                    last round had no occupied slot
//
// Build option: define ESCALONADOR_RODIZIO_EN for round-robin dispatch order;
// without it the lowest-index approved slot is dispatched first.

module escalonador_aprovados #(
  parameter int unsigned NUM_ATIVOS = 24,
  parameter int unsigned DIST_WIDTH = 8,
  parameter int unsigned SLOT_WIDTH = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  iniciar_in,
  output logic                  ocupado_out,
  input  logic [NUM_ATIVOS-1:0] valido_in,
  output logic                  ler_out,
  output logic [SLOT_WIDTH-1:0] ler_slot_out,
  input  logic [DIST_WIDTH-1:0] criterio_in,
  output logic [DIST_WIDTH-1:0] treshold_out,
  input  logic [NUM_ATIVOS-1:0] aprovados_in,
  output logic                  despacho_valido_out,
  output logic [SLOT_WIDTH-1:0] despacho_slot_out,
  input  logic                  despacho_pronto_in,
  output logic                  remover_out,
  output logic [SLOT_WIDTH-1:0] remover_slot_out,
  output logic                  fim_rodada_out,
  output logic                  vazio_out
);

  localparam logic [SLOT_WIDTH-1:0] ULTIMO_SLOT = SLOT_WIDTH'(NUM_ATIVOS - 1);

  typedef enum logic [2:0] {
    OCIOSO, VARRER, ESPERA, CAPTURAR, DESPACHAR, FIM
  } estado_t;

  estado_t               estado;
  logic [NUM_ATIVOS-1:0] mask_valido;
  logic [NUM_ATIVOS-1:0] pend;
  logic                  leitura_ant_vld;
  logic [SLOT_WIDTH-1:0] leitura_ant_slot;

  logic [NUM_ATIVOS-1:0] pend_captura_c;
  logic [NUM_ATIVOS-1:0] pend_restante_c;
  logic [SLOT_WIDTH-1:0] sel_captura_c;
  logic [SLOT_WIDTH-1:0] sel_restante_c;

  assign pend_captura_c  = aprovados_in & mask_valido;
  assign pend_restante_c = pend & ~(NUM_ATIVOS'(1) << despacho_slot_out);

`ifdef ESCALONADOR_RODIZIO_EN
  // Last accepted slot; survives across rounds.
  logic [SLOT_WIDTH-1:0] ponteiro;

  // First set bit strictly after base, wrapping past the last slot.
  function automatic logic [SLOT_WIDTH-1:0] primeiro_apos(
    input logic [NUM_ATIVOS-1:0] v,
    input logic [SLOT_WIDTH-1:0] base
  );
    logic [SLOT_WIDTH-1:0] res;
    logic [SLOT_WIDTH-1:0] idx;
    logic                  achou;
    res   = '0;
    achou = 1'b0;
    for (int unsigned i = 1; i <= NUM_ATIVOS; i++) begin
      idx = SLOT_WIDTH'((32'(base) + i) % NUM_ATIVOS);
      if (!achou && v[idx]) begin
        res   = idx;
        achou = 1'b1;
      end
    end
    return res;
  endfunction

  // After an accept the search restarts right after the accepted slot.
  assign sel_captura_c  = primeiro_apos(pend_captura_c, ponteiro);
  assign sel_restante_c = primeiro_apos(pend_restante_c, despacho_slot_out);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ponteiro <= ULTIMO_SLOT;
    end else if (estado == DESPACHAR && despacho_pronto_in) begin
      ponteiro <= despacho_slot_out;
    end
  end
`else
  // Lowest-index set bit.
  function automatic logic [SLOT_WIDTH-1:0] menor_indice(
    input logic [NUM_ATIVOS-1:0] v
  );
    logic [SLOT_WIDTH-1:0] res;
    logic [SLOT_WIDTH-1:0] idx;
    res = '0;
    for (int i = int'(NUM_ATIVOS) - 1; i >= 0; i--) begin
      idx = SLOT_WIDTH'(i);
      if (v[idx]) res = idx;
    end
    return res;
  endfunction

  assign sel_captura_c  = menor_indice(pend_captura_c);
  assign sel_restante_c = menor_indice(pend_restante_c);
`endif

  // Round sequencer; all outputs registered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      estado              <= OCIOSO;
      mask_valido         <= '0;
      pend                <= '0;
      leitura_ant_vld     <= 1'b0;
      leitura_ant_slot    <= '0;
      ocupado_out         <= 1'b0;
      ler_out             <= 1'b0;
      ler_slot_out        <= '0;
      treshold_out        <= '1;
      despacho_valido_out <= 1'b0;
      despacho_slot_out   <= '0;
      remover_out         <= 1'b0;
      remover_slot_out    <= '0;
      fim_rodada_out      <= 1'b0;
      vazio_out           <= 1'b0;
    end else begin
      remover_out      <= 1'b0;
      fim_rodada_out   <= 1'b0;
      leitura_ant_vld  <= ler_out;
      leitura_ant_slot <= ler_slot_out;

      // Read data arrives one cycle after the strobe; only occupied slots count.
      if (leitura_ant_vld && mask_valido[leitura_ant_slot] &&
          (criterio_in < treshold_out)) begin
        treshold_out <= criterio_in;
      end

      case (estado)
        OCIOSO: begin
          if (iniciar_in) begin
            mask_valido  <= valido_in;
            treshold_out <= '1;
            ler_out      <= 1'b1;
            ler_slot_out <= '0;
            ocupado_out  <= 1'b1;
            estado       <= VARRER;
          end
        end
        VARRER: begin
          if (ler_slot_out == ULTIMO_SLOT) begin
            ler_out      <= 1'b0;
            ler_slot_out <= '0;
            estado       <= ESPERA;
          end else begin
            ler_slot_out <= ler_slot_out + SLOT_WIDTH'(1);
          end
        end
        ESPERA: begin
          estado <= CAPTURAR;
        end
        CAPTURAR: begin
          pend      <= pend_captura_c;
          vazio_out <= (mask_valido == '0);
          if (pend_captura_c == '0) begin
            fim_rodada_out <= 1'b1;
            estado         <= FIM;
          end else begin
            despacho_valido_out <= 1'b1;
            despacho_slot_out   <= sel_captura_c;
            estado              <= DESPACHAR;
          end
        end
        DESPACHAR: begin
          if (despacho_pronto_in) begin
            pend             <= pend_restante_c;
            remover_out      <= 1'b1;
            remover_slot_out <= despacho_slot_out;
            if (pend_restante_c == '0) begin
              despacho_valido_out <= 1'b0;
              fim_rodada_out      <= 1'b1;
              estado              <= FIM;
            end else begin
              despacho_slot_out <= sel_restante_c;
            end
          end
        end
        FIM: begin
          ocupado_out <= 1'b0;
          estado      <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_aprovados.sv
// Self-checking bench for escalonador_aprovados: criterion store model,
// dispatch/removal scoreboard and one task per scenario.

module tb_escalonador_aprovados;

  localparam int unsigned N  = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 5;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          iniciar_in;
  logic          ocupado_out;
  logic [N-1:0]  valido_in;
  logic          ler_out;
  logic [SW-1:0] ler_slot_out;
  logic [DW-1:0] criterio_in;
  logic [DW-1:0] treshold_out;
  logic [N-1:0]  aprovados_in;
  logic          despacho_valido_out;
  logic [SW-1:0] despacho_slot_out;
  logic          despacho_pronto_in;
  logic          remover_out;
  logic [SW-1:0] remover_slot_out;
  logic          fim_rodada_out;
  logic          vazio_out;

  escalonador_aprovados #(.NUM_ATIVOS(N), .DIST_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .iniciar_in         (iniciar_in),
    .ocupado_out        (ocupado_out),
    .valido_in          (valido_in),
    .ler_out            (ler_out),
    .ler_slot_out       (ler_slot_out),
    .criterio_in        (criterio_in),
    .treshold_out       (treshold_out),
    .aprovados_in       (aprovados_in),
    .despacho_valido_out(despacho_valido_out),
    .despacho_slot_out  (despacho_slot_out),
    .despacho_pronto_in (despacho_pronto_in),
    .remover_out        (remover_out),
    .remover_slot_out   (remover_slot_out),
    .fim_rodada_out     (fim_rodada_out),
    .vazio_out          (vazio_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Criterion store: one-cycle read latency.
  logic [DW-1:0] crit [N];
  always @(posedge clk_in) if (ler_out) criterio_in <= crit[ler_slot_out];

  // Scoreboard: expected dispatch order, and the removal owed one cycle later.
  logic [SW-1:0] exp_desp [$];
  bit            mon_en = 1'b0;
  bit            rem_due = 1'b0;
  logic [SW-1:0] rem_slot_exp = '0;

  always @(negedge clk_in) begin
    if (mon_en) begin
      if (rem_due || remover_out) begin
        n_cmp++;
        if (remover_out !== 1'b1 || !rem_due || remover_slot_out !== rem_slot_exp) begin
          n_err++;
          $display("FAIL remover: got pulse=%b slot=%0d required pulse=%b slot=%0d",
                   remover_out, remover_slot_out, rem_due, rem_slot_exp);
        end
      end
      rem_due = 1'b0;
      if (despacho_valido_out && despacho_pronto_in) begin
        n_cmp++;
        if (exp_desp.size() == 0) begin
          n_err++;
          $display("FAIL despacho_extra: got slot %0d required no dispatch", despacho_slot_out);
        end else begin
          rem_slot_exp = exp_desp.pop_front();
          if (despacho_slot_out !== rem_slot_exp) begin
            n_err++;
            $display("FAIL despacho_ordem: got slot %0d required %0d",
                     despacho_slot_out, rem_slot_exp);
          end
        end
        rem_due = 1'b1;
      end
    end
  end

  function automatic logic [N-1:0] bits(input int a, input int b, input int c);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  // Starts a round; t0 is the cycle count of the edge that accepted the start.
  task automatic start_round(input logic [N-1:0] v, output int t0);
    @(posedge clk_in); #1;
    valido_in  = v;
    iniciar_in = 1'b1;
    @(posedge clk_in); #1;
    iniciar_in = 1'b0;
    @(negedge clk_in);
    t0 = cyc;
    n_cmp++;
    if ({ocupado_out, ler_out, ler_slot_out} !== {1'b1, 1'b1, SW'(0)}) begin
      n_err++;
      $display("FAIL inicio_varredura: got ocupado=%b ler=%b slot=%0d required 1 1 0",
               ocupado_out, ler_out, ler_slot_out);
    end
  endtask

  task automatic wait_valid(input int t0, output int lbl);
    lbl = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_in);
      if (despacho_valido_out === 1'b1) begin
        lbl = cyc - t0 + 1;
        break;
      end
    end
  endtask

  task automatic wait_fim(input int t0, output int lbl, output bit saw_valid);
    lbl = -1;
    saw_valid = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_in);
      if (despacho_valido_out === 1'b1) saw_valid = 1'b1;
      if (fim_rodada_out === 1'b1) begin
        lbl = cyc - t0 + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n_in           = 1'b0;
    iniciar_in         = 1'b0;
    valido_in          = '0;
    aprovados_in       = '0;
    despacho_pronto_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_cmp++;
    if ({ocupado_out, ler_out, ler_slot_out, despacho_valido_out, despacho_slot_out,
         remover_out, remover_slot_out, fim_rodada_out, vazio_out} !== '0) begin
      n_err++;
      $display("FAIL reset_saidas: got ocupado=%b ler=%b dv=%b rem=%b fim=%b vazio=%b required all 0",
               ocupado_out, ler_out, despacho_valido_out, remover_out, fim_rodada_out, vazio_out);
    end
    n_cmp++;
    if (treshold_out !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_treshold: got %0h required ff", treshold_out);
    end
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
  endtask

  task automatic test_basico;
    int t0, lbl;
    bit sv;
    for (int i = 0; i < int'(N); i++) crit[i] = 8'd1;
    crit[2] = 8'd7; crit[5] = 8'd3; crit[9] = 8'd3;
    aprovados_in       = bits(5, 9, -1);
    despacho_pronto_in = 1'b1;
    exp_desp.push_back(SW'(5));
    exp_desp.push_back(SW'(9));
    start_round(bits(2, 5, 9), t0);
    valido_in = '1;
    wait_valid(t0, lbl);
    n_cmp++;
    if (lbl != 27) begin
      n_err++;
      $display("FAIL basico_primeira_oferta: got cycle %0d required 27", lbl);
    end
    wait_fim(t0, lbl, sv);
    n_cmp++;
    if (lbl != 29) begin
      n_err++;
      $display("FAIL basico_fim: got cycle %0d required 29", lbl);
    end
    n_cmp++;
    if (treshold_out !== 8'd3 || vazio_out !== 1'b0) begin
      n_err++;
      $display("FAIL basico_treshold: got %0d vazio=%b required 3 vazio=0", treshold_out, vazio_out);
    end
    n_cmp++;
    if (exp_desp.size() != 0) begin
      n_err++;
      $display("FAIL basico_pendentes: got %0d left required 0", exp_desp.size());
    end
    @(negedge clk_in);
    n_cmp++;
    if (ocupado_out !== 1'b0 || treshold_out !== 8'd3) begin
      n_err++;
      $display("FAIL basico_ocioso: got ocupado=%b treshold=%0d required 0 3", ocupado_out, treshold_out);
    end
  endtask

  task automatic test_vazio;
    int t0, lbl;
    bit sv;
    aprovados_in       = '1;
    despacho_pronto_in = 1'b1;
    start_round('0, t0);
    wait_fim(t0, lbl, sv);
    n_cmp++;
    if (lbl != 27 || sv) begin
      n_err++;
      $display("FAIL vazio_fim: got cycle %0d dispatch=%b required 27 0", lbl, sv);
    end
    n_cmp++;
    if (vazio_out !== 1'b1 || treshold_out !== 8'hFF) begin
      n_err++;
      $display("FAIL vazio_flags: got vazio=%b treshold=%0h required 1 ff", vazio_out, treshold_out);
    end
  endtask

  task automatic test_mascara;
    int t0, lbl;
    bit sv;
    for (int i = 0; i < int'(N); i++) crit[i] = 8'd9;
    crit[0] = 8'd0;
    crit[1] = 8'd4;
    aprovados_in       = bits(1, -1, -1);
    despacho_pronto_in = 1'b1;
    exp_desp.push_back(SW'(1));
    start_round(bits(1, -1, -1), t0);
    wait_fim(t0, lbl, sv);
    n_cmp++;
    if (treshold_out !== 8'd4 || vazio_out !== 1'b0 || lbl != 28) begin
      n_err++;
      $display("FAIL mascara: got treshold=%0d vazio=%b fim=%0d required 4 0 28",
               treshold_out, vazio_out, lbl);
    end
  endtask

  task automatic test_pronto_baixo;
    int t0, lbl;
    bit sv;
    crit[2] = 8'd5;
    crit[3] = 8'd6;
    aprovados_in       = bits(2, 3, -1);
    despacho_pronto_in = 1'b0;
    exp_desp.push_back(SW'(2));
    exp_desp.push_back(SW'(3));
    start_round(bits(2, 3, -1), t0);
    wait_valid(t0, lbl);
    aprovados_in = '1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk_in);
      n_cmp++;
      if (despacho_valido_out !== 1'b1 || despacho_slot_out !== SW'(2)) begin
        n_err++;
        $display("FAIL pronto_baixo_oferta: got valid=%b slot=%0d required 1 2",
                 despacho_valido_out, despacho_slot_out);
      end
    end
    @(posedge clk_in); #1;
    despacho_pronto_in = 1'b1;
    wait_fim(t0, lbl, sv);
    n_cmp++;
    if (lbl != 32 || exp_desp.size() != 0) begin
      n_err++;
      $display("FAIL pronto_baixo_fim: got cycle %0d left %0d required 32 0", lbl, exp_desp.size());
    end
  endtask

  task automatic test_iniciar_ocupado;
    int t0, lbl;
    bit sv;
    aprovados_in       = bits(4, 7, -1);
    despacho_pronto_in = 1'b0;
    exp_desp.push_back(SW'(4));
    exp_desp.push_back(SW'(7));
    start_round(bits(4, 7, -1), t0);
    wait_valid(t0, lbl);
    @(posedge clk_in); #1;
    iniciar_in = 1'b1;
    @(negedge clk_in);
    n_cmp++;
    if ({ocupado_out, despacho_valido_out, despacho_slot_out, ler_out} !== {1'b1, 1'b1, SW'(4), 1'b0}) begin
      n_err++;
      $display("FAIL iniciar_ignorado: got ocupado=%b valid=%b slot=%0d ler=%b required 1 1 4 0",
               ocupado_out, despacho_valido_out, despacho_slot_out, ler_out);
    end
    @(posedge clk_in); #1;
    iniciar_in         = 1'b0;
    despacho_pronto_in = 1'b1;
    wait_fim(t0, lbl, sv);
    repeat (2) @(negedge clk_in);
    n_cmp++;
    if (ocupado_out !== 1'b0 || ler_out !== 1'b0 || exp_desp.size() != 0) begin
      n_err++;
      $display("FAIL iniciar_nao_enfileirado: got ocupado=%b ler=%b left=%0d required 0 0 0",
               ocupado_out, ler_out, exp_desp.size());
    end
  endtask

  task automatic test_reset_meio;
    int t0, lbl;
    aprovados_in       = bits(3, 8, -1);
    despacho_pronto_in = 1'b0;
    start_round(bits(3, 8, -1), t0);
    wait_valid(t0, lbl);
    mon_en   = 1'b0;
    rst_n_in = 1'b0;
    #1;
    n_cmp++;
    if ({ocupado_out, ler_out, despacho_valido_out, despacho_slot_out, remover_out,
         fim_rodada_out, vazio_out} !== '0 || treshold_out !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_meio: got ocupado=%b valid=%b slot=%0d rem=%b treshold=%0h required 0 0 0 0 ff",
               ocupado_out, despacho_valido_out, despacho_slot_out, remover_out, treshold_out);
    end
    exp_desp.delete();
    rem_due = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in           = 1'b1;
    despacho_pronto_in = 1'b1;
    mon_en             = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      n_cmp++;
      if (remover_out !== 1'b0 || despacho_valido_out !== 1'b0 || ocupado_out !== 1'b0) begin
        n_err++;
        $display("FAIL reset_meio_apos: got rem=%b valid=%b ocupado=%b required 0 0 0",
                 remover_out, despacho_valido_out, ocupado_out);
      end
    end
  endtask

  // Pointer starts from reset value here (previous task reset the DUT).
  task automatic test_rodizio;
    int t0, lbl;
    bit sv;
    despacho_pronto_in = 1'b1;
    for (int r = 0; r < 3; r++) begin
      aprovados_in = (r == 2) ? bits(1, 4, 6) : bits(1, 4, -1);
`ifdef ESCALONADOR_RODIZIO_EN
      if (r == 2) exp_desp.push_back(SW'(6));
      exp_desp.push_back(SW'(1));
      exp_desp.push_back(SW'(4));
`else
      exp_desp.push_back(SW'(1));
      exp_desp.push_back(SW'(4));
      if (r == 2) exp_desp.push_back(SW'(6));
`endif
      start_round(bits(1, 4, 6), t0);
      wait_fim(t0, lbl, sv);
      n_cmp++;
      if (exp_desp.size() != 0 || lbl != ((r == 2) ? 30 : 29)) begin
        n_err++;
        $display("FAIL rodizio_rodada%0d: got fim=%0d left=%0d required %0d 0",
                 r, lbl, exp_desp.size(), (r == 2) ? 30 : 29);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_basico();
    test_vazio();
    test_mascara();
    test_pronto_baixo();
    test_iniciar_ocupado();
    test_reset_meio();
    test_rodizio();
    repeat (3) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
